// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-level
// constants for the R/W bit and ACK/NACK.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one raw I2C pad line: 2-flop synchronizer, optional 3-sample
// majority filter (I2C_TARGET_GLITCH_FILTER_EN) and rise/fall detection.
module i2c_line_cond (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;

    // Idle I2C lines are pulled high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       maj;

    assign maj = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= maj;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file: pointer write, sequential writes
// and reads, SCL never stretched. Optional input filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SDA_HOLD    = 4,
    localparam int        AW          = $clog2(NUM_REGS)
) (
    input  logic          S00_AXI_aclk,
    input  logic          S00_AXI_aresetn,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    input  logic [AW-1:0] loc_addr_i,
    output logic [7:0]    loc_rdata_o,
    output logic          wr_pulse_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o
);

    localparam int HW = $clog2(SDA_HOLD + 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_cond u_scl_cond (
        .clk_i   (S00_AXI_aclk),
        .rst_ni  (S00_AXI_aresetn),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_cond u_sda_cond (
        .clk_i   (S00_AXI_aclk),
        .rst_ni  (S00_AXI_aresetn),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e    state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          ackdone_q, ackdone_d;
    logic          mack_q, mack_d;
    logic          pend_q, pend_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          oe_q, oe_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    rx_byte;
    logic          load_rd;

    assign rx_byte = {shift_q[6:0], sda_lvl};

    // SDA changes are scheduled on a detected SCL fall and applied SDA_HOLD
    // cycles later; START/STOP release the line at once and cancel any pending change.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ackdone_d  = ackdone_q;
        mack_d     = mack_q;
        pend_d     = pend_q;
        hold_d     = hold_q;
        oe_d       = oe_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        load_rd    = 1'b0;

        if (hold_q != '0) begin
            if (hold_q == HW'(1)) begin
                oe_d = pend_q;
            end
            hold_d = hold_q - 1'b1;
        end

        if (start_det) begin
            state_d  = ST_ADDR;
            bitcnt_d = 4'd0;
            oe_d     = 1'b0;
            hold_d   = '0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d  = 4'd0;
                            ackdone_d = 1'b0;
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = rx_byte[AW-1:0];
                                state_d = ST_WR_ACK;
                            end else begin
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = rx_byte;
                                ptr_d      = ptr_q + 1'b1;
                                state_d    = ST_WR_ACK;
                            end
                        end
                    end
                end
                // First SCL fall starts the ACK drive; the fall after the 9th rise ends it.
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_rise) begin
                        ackdone_d = 1'b1;
                    end else if (scl_fall) begin
                        hold_d = HW'(SDA_HOLD);
                        if (!ackdone_q) begin
                            pend_d = ~I2C_ACK;
                        end else begin
                            bitcnt_d = 4'd0;
                            pend_d   = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                                load_rd = 1'b1;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        hold_d = HW'(SDA_HOLD);
                        if (bitcnt_q == 4'd8) begin
                            state_d   = ST_RD_ACK;
                            ackdone_d = 1'b0;
                            pend_d    = 1'b0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            pend_d  = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ackdone_d = 1'b1;
                        mack_d    = (sda_lvl == I2C_ACK);
                    end else if (scl_fall && ackdone_q) begin
                        bitcnt_d = 4'd0;
                        if (mack_q) begin
                            load_rd = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            pend_d  = 1'b0;
                            hold_d  = HW'(SDA_HOLD);
                        end
                    end
                end
                default: begin
                end
            endcase

            if (load_rd) begin
                state_d = ST_RD_DATA;
                shift_d = regs_q[ptr_q];
                ptr_d   = ptr_q + 1'b1;
                pend_d  = ~regs_q[ptr_q][7];
                hold_d  = HW'(SDA_HOLD);
            end
        end
    end

    always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
        if (!S00_AXI_aresetn) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= '0;
            rw_q       <= I2C_RW_WRITE;
            ackdone_q  <= 1'b0;
            mack_q     <= 1'b0;
            pend_q     <= 1'b0;
            hold_q     <= '0;
            oe_q       <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ackdone_q  <= ackdone_d;
            mack_q     <= mack_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            oe_q       <= oe_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge S00_AXI_aclk or negedge S00_AXI_aresetn) begin
        if (!S00_AXI_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_pulse_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign sda_oe_o    = oe_q;
    assign wr_pulse_o  = wr_pulse_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign loc_rdata_o = regs_q[loc_addr_i];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench for i2c_target_regs: a bit-level I2C master issues
// transactions, expected ACKs/read bytes/write strobes are queued and checked by monitors.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int Q = 10;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rstN;
    logic       sclM;
    logic       sdaM;
    logic       sdaBus;
    logic       sdaOe;
    logic [3:0] locAddr;
    logic [7:0] locRdata;
    logic       wrPulse;
    logic [3:0] wrAddr;
    logic [7:0] wrData;

    int checks;
    int fails;

    exp_t        expBus[$];
    logic [11:0] expWr[$];
    logic [7:0]  obsVal;
    event        obsEv;

    i2c_target_regs #(
        .TARGET_ADDR (7'h50),
        .NUM_REGS    (16),
        .SDA_HOLD    (4)
    ) dut (
        .S00_AXI_aclk    (clk),
        .S00_AXI_aresetn (rstN),
        .scl_i           (sclM),
        .sda_i           (sdaBus),
        .sda_oe_o        (sdaOe),
        .loc_addr_i      (locAddr),
        .loc_rdata_o     (locRdata),
        .wr_pulse_o      (wrPulse),
        .wr_addr_o       (wrAddr),
        .wr_data_o       (wrData)
    );

    assign sdaBus = sdaM & ~sdaOe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for bus responses (ACK bits and read bytes) observed by the master.
    initial begin
        exp_t e;
        forever begin
            @(obsEv);
            if (expBus.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_bus_obs: got 0x%0h, expected nothing", obsVal);
            end else begin
                e = expBus.pop_front();
                checkOutput(e.name, {8'h00, obsVal}, {8'h00, e.val});
            end
        end
    end

    // Monitor for register write strobes.
    always @(negedge clk) begin
        if (rstN && wrPulse === 1'b1) begin
            if (expWr.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", wrAddr, wrData);
            end else begin
                checkOutput("wr_strobe", {4'h0, wrAddr, wrData}, {4'h0, expWr.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitQ;
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic busStart;
        sdaM = 1'b1; waitQ;
        sclM = 1'b1; waitQ;
        sdaM = 1'b0; waitQ;
        sclM = 1'b0; waitQ;
    endtask

    task automatic busStop;
        sdaM = 1'b0; waitQ;
        sclM = 1'b1; waitQ;
        sdaM = 1'b1; waitQ;
        waitQ;
    endtask

    task automatic writeBit(input logic b);
        sdaM = b; waitQ;
        sclM = 1'b1; waitQ;
        waitQ;
        sclM = 1'b0; waitQ;
    endtask

    task automatic readBit(output logic b);
        sdaM = 1'b1; waitQ;
        sclM = 1'b1; waitQ;
        b = sdaBus; waitQ;
        sclM = 1'b0; waitQ;
    endtask

    task automatic sendByte(input logic [7:0] d, input logic expAck, input string name);
        exp_t e;
        logic a;
        e.name = name;
        e.val  = {7'b0, expAck ? I2C_ACK : I2C_NACK};
        expBus.push_back(e);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(a);
        obsVal = {7'b0, a};
        ->obsEv;
    endtask

    task automatic recvByte(input logic [7:0] exp, input logic mAck, input string name);
        exp_t e;
        logic [7:0] d;
        logic b;
        e.name = name;
        e.val  = exp;
        expBus.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            d[i] = b;
        end
        obsVal = d;
        ->obsEv;
        writeBit(mAck ? I2C_ACK : I2C_NACK);
    endtask

    task automatic checkReg(input logic [3:0] idx, input logic [7:0] exp, input string name);
        locAddr = idx;
        #1;
        checkOutput(name, {8'h00, locRdata}, {8'h00, exp});
    endtask

    task automatic applyStimulus;
        // Reset state
        checkOutput("rst_sda_oe", {15'h0, sdaOe}, 16'h0);
        checkOutput("rst_wr_pulse", {15'h0, wrPulse}, 16'h0);
        checkOutput("rst_wr_addr", {12'h0, wrAddr}, 16'h0);
        checkOutput("rst_wr_data", {8'h0, wrData}, 16'h0);
        checkReg(4'd3, 8'h00, "rst_reg3");

        // Pointer write then two data bytes
        busStart;
        sendByte(8'hA0, 1'b1, "t1_addr_ack");
        sendByte(8'h03, 1'b1, "t1_ptr_ack");
        expWr.push_back({4'd3, 8'hA5});
        sendByte(8'hA5, 1'b1, "t1_d0_ack");
        expWr.push_back({4'd4, 8'h5A});
        sendByte(8'h5A, 1'b1, "t1_d1_ack");
        busStop;
        checkReg(4'd3, 8'hA5, "t1_reg3");
        checkReg(4'd4, 8'h5A, "t1_reg4");

        // Pointer write, repeated START, sequential read with final NACK
        busStart;
        sendByte(8'hA0, 1'b1, "t2_addr_ack");
        sendByte(8'h02, 1'b1, "t2_ptr_ack");
        busStart;
        sendByte(8'hA1, 1'b1, "t2_raddr_ack");
        recvByte(8'h00, 1'b1, "t2_rd_reg2");
        recvByte(8'hA5, 1'b1, "t2_rd_reg3");
        recvByte(8'h5A, 1'b0, "t2_rd_reg4");
        checkOutput("t2_release_after_nack", {15'h0, sdaOe}, 16'h0);
        busStop;

        // Wrong address: NACK everything, no writes
        busStart;
        sendByte(8'hA2, 1'b0, "t3_addr_nack");
        sendByte(8'h03, 1'b0, "t3_d0_nack");
        sendByte(8'hFF, 1'b0, "t3_d1_nack");
        busStop;
        checkReg(4'd3, 8'hA5, "t3_reg3_kept");

        // Pointer wrap from 15 to 0
        busStart;
        sendByte(8'hA0, 1'b1, "t4_addr_ack");
        sendByte(8'h0F, 1'b1, "t4_ptr_ack");
        expWr.push_back({4'd15, 8'h11});
        sendByte(8'h11, 1'b1, "t4_d0_ack");
        expWr.push_back({4'd0, 8'h22});
        sendByte(8'h22, 1'b1, "t4_d1_ack");
        busStop;
        checkReg(4'd15, 8'h11, "t4_reg15");
        checkReg(4'd0, 8'h22, "t4_reg0");

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // Single-cycle SDA low pulse while SCL high must not look like START
        @(posedge clk); #1;
        sdaM = 1'b0;
        @(posedge clk); #1;
        sdaM = 1'b1;
        waitQ;
        sclM = 1'b0; waitQ;
        sendByte(8'hA0, 1'b0, "t6_glitch_no_start");
        busStop;
`endif

        // Reset asserted while the address ACK is being driven
        busStart;
        for (int i = 7; i >= 0; i--) writeBit(((8'hA0 >> i) & 8'h01) != 8'h00);
        sdaM = 1'b1; waitQ;
        sclM = 1'b1; waitQ;
        checkOutput("t5_ack_driven", {15'h0, sdaOe}, 16'h1);
        rstN = 1'b0;
        #1;
        checkOutput("t5_async_release", {15'h0, sdaOe}, 16'h0);
        waitQ;
        rstN = 1'b1;
        waitQ;
        sclM = 1'b0; waitQ;
        busStop;
        checkReg(4'd3, 8'h00, "t5_reg3_cleared");

        busStart;
        sendByte(8'hA0, 1'b1, "t5_addr_ack");
        sendByte(8'h07, 1'b1, "t5_ptr_ack");
        expWr.push_back({4'd7, 8'h3C});
        sendByte(8'h3C, 1'b1, "t5_d0_ack");
        busStart;
        sendByte(8'hA0, 1'b1, "t5_addr2_ack");
        sendByte(8'h07, 1'b1, "t5_ptr2_ack");
        busStart;
        sendByte(8'hA1, 1'b1, "t5_raddr_ack");
        recvByte(8'h3C, 1'b0, "t5_rd_reg7");
        busStop;
        checkReg(4'd7, 8'h3C, "t5_reg7");
        checkOutput("idle_sda_oe", {15'h0, sdaOe}, 16'h0);
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        rstN    = 1'b0;
        sclM    = 1'b1;
        sdaM    = 1'b1;
        locAddr = 4'd0;
        repeat (5) @(posedge clk);
        #1;
        rstN = 1'b1;
        waitQ;
        applyStimulus;
        waitQ;
        checkOutput("bus_queue_drained", 16'(expBus.size()), 16'h0);
        checkOutput("wr_queue_drained", 16'(expWr.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
